pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the `wren` of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and a per-register bubble strobe. It resolves load-use hazards, variable-latency RAM waits and taken-branch redirects, and traps a hung RAM access. It also keeps saturating stall/flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive RAM-wait stall cycles before fault (>=2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- id_rs1_address  in  5  rs1 of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_address  in  5  rs2 of the instruction in ID.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd_address  in  5  rd held in ID/EX.
- ex_reg_wren  in  1  ID/EX instruction writes a register.
- ex_is_load  in  1  ID/EX instruction's writeback data comes from RAM.
- mem_ram_access  in  1  EX/MEM instruction is a load or store.
- mem_ready  in  1  RAM completes the access this cycle.
- mem_branch_taken  in  1  EX/MEM instruction redirects the PC (resolved `next_pc_src`).
- pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren  out  1 each  register write enables.
- if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1 each  when the matching wren=1, that register loads a NOP (zeros `reg_wren`, `ram_wren` and `next_pc_src`).
- fault  out  1  sticky RAM-timeout trap.
- stall_count  out  CNT_W  cycles with pc_wren=0, excluding reset and FAULT.
- flush_count  out  CNT_W  taken-branch redirect cycles.

## Operation
- States: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- Hazard terms:
  - memstall = mem_ram_access & !mem_ready, valid in RUN or MEM_WAIT.
  - loaduse = ex_is_load & ex_reg_wren & ex_rd_address!=0 & ((id_rs1_used & rs1==ex_rd_address) | (id_rs2_used & rs2==ex_rd_address)).
- Priority: FAULT > memstall > mem_branch_taken > loaduse > normal.
- FAULT: all wren=0, all bubbles=0, fault=1. Only reset_n leaves FAULT.
- memstall: pc, if_id, id_ex and ex_mem wren=0. mem_wb_wren=1 with mem_wb_bubble=1.
- branch: all wren=1. if_id, id_ex and ex_mem bubbles=1. PC loads the target. The ID instruction is squashed, so loaduse is ignored.
- loaduse: pc_wren=0, if_id_wren=0. id_ex_wren=1 with id_ex_bubble=1. ex_mem and mem_wb wren=1.
- normal: all wren=1, no bubbles.
- Outputs are combinational from state and inputs. State, wait counter and perf counters are registered.
- Transitions:
  - RUN→MEM_WAIT on memstall. wait_cnt←1.
  - MEM_WAIT & !mem_ready: wait_cnt+1. When wait_cnt==MEM_TIMEOUT-1 and still not ready, go to FAULT.
  - MEM_WAIT & mem_ready: release this cycle (apply branch/loaduse/normal rules), go to RUN, wait_cnt←0.
- Counters saturate at all-ones. Both hold in FAULT.
- mem_branch_taken together with mem_ram_access is illegal; memstall or mem_ready handling takes precedence, and the branch is acted on once the stall releases.
- Reset (reset_n=0): all wren=0, all bubbles=1, state RUN, wait_cnt=0, fault=0, counters=0. Reset asserted mid-MEM_WAIT or in FAULT returns to RUN on the next edge.

## Timing
- Zero-cycle control: wren and bubbles act at the same clk edge as their inputs.
- Load-use costs exactly 1 stall cycle. After that, the load sits in EX/MEM and the forwarding path covers the dependency.
- A taken branch costs 3 squashed slots (IF/ID, ID/EX, EX/MEM).
- RAM access with mem_ready in the first cycle: 0 stalls. Ready after N cycles: N stalls.
- Total stall cycles ≥ MEM_TIMEOUT without ready: fault=1 from the following cycle.

## Structure
- Shared package `cpu_pipeline_pkg`: state enum (RUN/MEM_WAIT/FAULT), REG_ADDR_W=5, NOP field constants reused by all pipeline registers.
- Sub-module `sat_counter` (parameter W; inc, clear), instantiated twice for the performance counters.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, ex_reg_wren=1, id_rs2=5 used → one cycle with pc_wren=if_id_wren=0 and id_ex_bubble=1; stall_count=1.
- rd=x0: same stimulus with ex_rd=0 → no stall, all wren=1.
- RAM wait: mem_ram_access=1, mem_ready low 3 cycles then high → 3 cycles of ex_mem_wren=0 with mem_wb_bubble=1, release on cycle 4; stall_count=3.
- Branch plus load-use: mem_branch_taken=1 with loaduse true → all wren=1, three bubbles, flush_count=1.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → fault=1 after 4 stalls, all wren=0, counters frozen; reset_n=0 for 1 cycle → RUN, fault=0.
- Saturation: CNT_W=3, 9 load-use stalls → stall_count=7.

Source files
------------

// File: rtl/cpu_pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline control path.
//   - hazard_state_t : hazard sequencer state (RUN / MEM_WAIT / FAULT)
//   - REG_ADDR_W     : register-file address width
//   - NOP_*          : field values a pipeline register loads on a bubble
//   - pipe_ctrl_t    : bundle of register write enables and bubble strobes
//   - reg_dep()      : "source operand depends on rd" helper
package cpu_pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hazard_state_t;

    // A bubble turns the captured instruction into a NOP by clearing the
    // fields that carry architectural side effects.
    localparam logic NOP_REG_WREN    = 1'b0;
    localparam logic NOP_RAM_WREN    = 1'b0;
    localparam logic NOP_NEXT_PC_SRC = 1'b0;

    typedef struct packed {
        logic pc_wren;
        logic if_id_wren;
        logic id_ex_wren;
        logic ex_mem_wren;
        logic mem_wb_wren;
        logic if_id_bubble;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    //                                      pc    ifid  idex  exmem memwb ifidB idexB exmemB memwbB
    localparam pipe_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctrl_t CTRL_HALT     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_MEMSTALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam pipe_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic logic reg_dep(input logic [REG_ADDR_W-1:0] src,
                                     input logic                  used,
                                     input logic [REG_ADDR_W-1:0] rd);
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk   : clock
//   clear : synchronous clear to zero (dominates inc)
//   inc   : add one this cycle unless already at all-ones
//   count : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline.
// Drives the write enable and bubble strobe of every pipeline register,
// resolving RAM waits, taken-branch redirects and load-use hazards, and
// traps a RAM access that never completes.
//   clk, reset_n               : clock, synchronous active-low reset
//   id_rs1/rs2_address/_used   : source operands of the ID instruction
//   ex_rd_address, ex_reg_wren,
//   ex_is_load                 : destination info of the ID/EX instruction
//   mem_ram_access, mem_ready  : EX/MEM RAM access and its completion
//   mem_branch_taken           : EX/MEM instruction redirects the PC
//   *_wren, *_bubble           : pipeline register controls (combinational)
//   fault                      : sticky RAM-timeout trap
//   stall_count, flush_count   : saturating performance counters
module pipeline_hazard_controller
    import cpu_pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_address,
    input  logic                  ex_reg_wren,
    input  logic                  ex_is_load,
    input  logic                  mem_ram_access,
    input  logic                  mem_ready,
    input  logic                  mem_branch_taken,
    output logic                  pc_wren,
    output logic                  if_id_wren,
    output logic                  id_ex_wren,
    output logic                  ex_mem_wren,
    output logic                  mem_wb_wren,
    output logic                  if_id_bubble,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  mem_wb_bubble,
    output logic                  fault,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    pipe_ctrl_t        ctrl;
    logic              memstall;
    logic              loaduse;
    logic              stall_inc;
    logic              flush_inc;

    assign memstall = mem_ram_access & ~mem_ready;

    // A load to x0 never produces a value, so it cannot create a hazard.
    assign loaduse = ex_is_load & ex_reg_wren & (ex_rd_address != '0) &
                     (reg_dep(id_rs1_address, id_rs1_used, ex_rd_address) |
                      reg_dep(id_rs2_address, id_rs2_used, ex_rd_address));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        ctrl          = CTRL_NORMAL;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        flush_inc     = 1'b0;

        if (!reset_n) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (memstall) begin
                        // RAM wait dominates everything else, including an
                        // (illegal) concurrent branch: the branch is taken
                        // up in the release cycle instead.
                        ctrl = CTRL_MEMSTALL;
                        if (state == RUN) begin
                            state_next    = MEM_WAIT;
                            wait_cnt_next = WAIT_W'(1);
                        end else if (wait_cnt == WAIT_LAST) begin
                            state_next = FAULT;
                        end else begin
                            wait_cnt_next = wait_cnt + 1'b1;
                        end
                    end else begin
                        state_next    = RUN;
                        wait_cnt_next = '0;
                        if (mem_branch_taken) begin
                            // ID instruction is squashed, so its load-use
                            // dependency is irrelevant.
                            ctrl      = CTRL_BRANCH;
                            flush_inc = 1'b1;
                        end else if (loaduse) begin
                            ctrl = CTRL_LOADUSE;
                        end
                    end
                end
                FAULT: begin
                    ctrl = CTRL_HALT;
                end
                default: begin
                    ctrl          = CTRL_HALT;
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            endcase
        end
    end

    assign stall_inc = reset_n & (state != FAULT) & ~ctrl.pc_wren;
    assign fault     = reset_n & (state == FAULT);

    assign pc_wren       = ctrl.pc_wren;
    assign if_id_wren    = ctrl.if_id_wren;
    assign id_ex_wren    = ctrl.id_ex_wren;
    assign ex_mem_wren   = ctrl.ex_mem_wren;
    assign mem_wb_wren   = ctrl.mem_wb_wren;
    assign if_id_bubble  = ctrl.if_id_bubble;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;

    sat_counter #(.W(CNT_W)) u_stall_counter (
        .clk   (clk),
        .clear (~reset_n),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_counter (
        .clk   (clk),
        .clear (~reset_n),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with MEM_TIMEOUT=4, CNT_W=3.
// Expected control vectors are queued as each step is driven and popped and
// compared when the outputs are sampled on the falling edge.
module tb_pipeline_hazard_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    // {pc, if_id, id_ex, ex_mem, mem_wb wren, if_id, id_ex, ex_mem, mem_wb bubble, fault}
    localparam logic [9:0] V_NORMAL   = 10'b11111_0000_0;
    localparam logic [9:0] V_RESET    = 10'b00000_1111_0;
    localparam logic [9:0] V_MEMSTALL = 10'b00001_0001_0;
    localparam logic [9:0] V_BRANCH   = 10'b11111_1110_0;
    localparam logic [9:0] V_LOADUSE  = 10'b00111_0100_0;
    localparam logic [9:0] V_FAULT    = 10'b00000_0000_1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [4:0]       id_rs1_address, id_rs2_address, ex_rd_address;
    logic             id_rs1_used, id_rs2_used, ex_reg_wren, ex_is_load;
    logic             mem_ram_access, mem_ready, mem_branch_taken;
    logic             pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
    logic             if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
    logic             fault;
    logic [CNT_W-1:0] stall_count, flush_count;

    typedef struct {
        string      tag;
        logic [9:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_rs1_address   (id_rs1_address),
        .id_rs1_used      (id_rs1_used),
        .id_rs2_address   (id_rs2_address),
        .id_rs2_used      (id_rs2_used),
        .ex_rd_address    (ex_rd_address),
        .ex_reg_wren      (ex_reg_wren),
        .ex_is_load       (ex_is_load),
        .mem_ram_access   (mem_ram_access),
        .mem_ready        (mem_ready),
        .mem_branch_taken (mem_branch_taken),
        .pc_wren          (pc_wren),
        .if_id_wren       (if_id_wren),
        .id_ex_wren       (id_ex_wren),
        .ex_mem_wren      (ex_mem_wren),
        .mem_wb_wren      (mem_wb_wren),
        .if_id_bubble     (if_id_bubble),
        .id_ex_bubble     (id_ex_bubble),
        .ex_mem_bubble    (ex_mem_bubble),
        .mem_wb_bubble    (mem_wb_bubble),
        .fault            (fault),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    task automatic clear_inputs();
        id_rs1_address   = 5'd0;
        id_rs1_used      = 1'b0;
        id_rs2_address   = 5'd0;
        id_rs2_used      = 1'b0;
        ex_rd_address    = 5'd0;
        ex_reg_wren      = 1'b0;
        ex_is_load       = 1'b0;
        mem_ram_access   = 1'b0;
        mem_ready        = 1'b0;
        mem_branch_taken = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic rs1_u,
                            input logic [4:0] rs2, input logic rs2_u);
        ex_is_load     = 1'b1;
        ex_reg_wren    = 1'b1;
        ex_rd_address  = rd;
        id_rs1_address = rs1;
        id_rs1_used    = rs1_u;
        id_rs2_address = rs2;
        id_rs2_used    = rs2_u;
    endtask

    // Inputs for this cycle are already driven; queue the expectation, check
    // on the falling edge, then let the rising edge commit the cycle.
    task automatic step(input string tag, input logic [9:0] exp_vec);
        exp_t       e;
        logic [9:0] obs;
        e.tag = tag;
        e.vec = exp_vec;
        sb.push_back(e);
        @(negedge clk);
        obs = {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
               if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, fault};
        e = sb.pop_front();
        n_tests++;
        assert (obs === e.vec) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp_stall,
                           input logic [CNT_W-1:0] exp_flush);
        n_tests++;
        assert (stall_count === exp_stall) else begin
            n_fail++;
            $error("FAIL %s stall_count: observed %0d expected %0d", tag, stall_count, exp_stall);
        end
        n_tests++;
        assert (flush_count === exp_flush) else begin
            n_fail++;
            $error("FAIL %s flush_count: observed %0d expected %0d", tag, flush_count, exp_flush);
        end
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        reset_n = 1'b0;
        step(tag, V_RESET);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        step("reset_outputs", V_RESET);
        chk_cnt("reset", 3'd0, 3'd0);
        reset_n = 1'b1;

        // Load-use on rs2, then on rs1; each costs one cycle.
        set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        step("loaduse_rs2", V_LOADUSE);
        clear_inputs();
        step("loaduse_rs2_after", V_NORMAL);
        chk_cnt("loaduse_rs2", 3'd1, 3'd0);
        set_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        step("loaduse_rs1", V_LOADUSE);
        // Matching address but operand unused, non-load, and rd=x0 cases.
        set_load(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        step("match_unused", V_NORMAL);
        set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        ex_is_load = 1'b0;
        step("not_load", V_NORMAL);
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step("rd_x0", V_NORMAL);
        chk_cnt("after_loaduse", 3'd2, 3'd0);

        // RAM wait of 3 cycles then ready.
        do_reset("reset_ram");
        chk_cnt("reset_ram", 3'd0, 3'd0);
        mem_ram_access = 1'b1;
        for (int i = 0; i < 3; i++) step("ram_wait", V_MEMSTALL);
        mem_ready = 1'b1;
        step("ram_release", V_NORMAL);
        chk_cnt("ram_wait", 3'd3, 3'd0);
        step("ram_ready_first", V_NORMAL);
        chk_cnt("ram_ready_first", 3'd3, 3'd0);

        // Branch overrides load-use.
        clear_inputs();
        set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        mem_branch_taken = 1'b1;
        step("branch_loaduse", V_BRANCH);
        chk_cnt("branch_loaduse", 3'd3, 3'd1);

        // Branch presented during a RAM stall is deferred to the release.
        clear_inputs();
        mem_ram_access   = 1'b1;
        mem_branch_taken = 1'b1;
        step("branch_in_stall", V_MEMSTALL);
        mem_ready = 1'b1;
        step("branch_on_release", V_BRANCH);
        chk_cnt("branch_deferred", 3'd4, 3'd2);
        clear_inputs();
        step("post_branch", V_NORMAL);

        // Hung RAM access traps after MEM_TIMEOUT stall cycles.
        do_reset("reset_timeout");
        mem_ram_access = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) step("timeout_wait", V_MEMSTALL);
        chk_cnt("timeout_stalls", 3'd4, 3'd0);
        step("fault_entered", V_FAULT);
        mem_ready        = 1'b1;
        mem_branch_taken = 1'b1;
        set_load(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        step("fault_sticky", V_FAULT);
        chk_cnt("fault_frozen", 3'd4, 3'd0);
        do_reset("reset_from_fault");
        chk_cnt("reset_from_fault", 3'd0, 3'd0);
        step("run_after_fault", V_NORMAL);

        // Reset in the middle of a RAM wait returns to RUN.
        mem_ram_access = 1'b1;
        step("midwait_1", V_MEMSTALL);
        step("midwait_2", V_MEMSTALL);
        do_reset("reset_midwait");
        step("run_after_midwait", V_NORMAL);

        // Stall counter saturates at 7 with CNT_W=3.
        set_load(5'd6, 5'd0, 1'b0, 5'd6, 1'b1);
        for (int i = 0; i < 9; i++) step("sat_loaduse", V_LOADUSE);
        chk_cnt("saturation", 3'd7, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
